// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC frame scheduler.
package dac_sched_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

    localparam int DAC_BITS = 16;
    localparam int CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_SCK_LAST = 5'd16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requester at or after the pointer, pointer moves past the grant on advance.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic                              advance,
    output logic [idx_width(NUM_REQ)-1:0]     grant_idx,
    output logic                              any_req
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               idx;

    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Scan from the farthest offset down so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req[idx]) begin
                any_req   = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dac_frame_sched.sv
// Shares one 16-bit DAC between NUM_REQ requesters: LOAD, SHIFT 16 bits, wait for ldac, ack, GAP.
// Optional ldac timeout with err pulse is enabled by defining DAC_SCHED_TIMEOUT_EN.
module dac_frame_sched
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SCK_HALF     = 4,
    parameter int GAP_CYC      = 8,
    parameter int LDAC_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_state,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [DAC_BITS*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DAC_BITS-1:0]          data_sdi,
    output logic                         cs,
    output logic                         sck,
    output logic [CNT_W-1:0]             cnt_sck,
    input  logic                         ldac,
    output logic                         busy,
    output logic                         err
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int TMR_MAX = (2*SCK_HALF > GAP_CYC)
        ? ((2*SCK_HALF > LDAC_TIMEOUT) ? 2*SCK_HALF : LDAC_TIMEOUT)
        : ((GAP_CYC > LDAC_TIMEOUT) ? GAP_CYC : LDAC_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] BIT_LAST = TMR_W'(2*SCK_HALF - 1);
    localparam logic [TMR_W-1:0] SCK_RISE = TMR_W'(SCK_HALF);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
`ifdef DAC_SCHED_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LDAC_TIMEOUT - 1);
`endif

    state_t               state_q, state_d;
    logic                 cs_q, cs_d;
    logic                 sck_q, sck_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DAC_BITS-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 seen_q, seen_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;

    logic [IDX_W-1:0]     grant_idx;
    logic                 any_req;
    logic                 advance;

    assign advance = (state_q == IDLE) && key_state && any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = 1'b0;
        seen_d  = seen_q;
        grant_d = grant_q;
        tmr_d   = tmr_q;

        case (state_q)
            IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                cnt_d = '0;
                if (any_req) begin
                    data_d  = req_data[int'(grant_idx)*DAC_BITS +: DAC_BITS];
                    grant_d = grant_idx;
                    tmr_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (tmr_q == TMR_W'(1)) begin
                    tmr_d   = '0;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_q == BIT_LAST) begin
                    tmr_d = '0;
                    sck_d = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                    // Last bit period ends: cs rises together with cnt_sck reaching 16.
                    if (cnt_q == CNT_SCK_LAST - 1'b1) begin
                        cs_d    = 1'b1;
                        seen_d  = 1'b0;
                        state_d = LATCH;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    sck_d = ((tmr_q + 1'b1) >= SCK_RISE);
                end
            end
            LATCH: begin
                if (seen_q && ldac) begin
                    ack_d[grant_q] = 1'b1;
                    cnt_d          = '0;
                    tmr_d          = '0;
                    state_d        = GAP;
                end else begin
                    if (!ldac) begin
                        seen_d = 1'b1;
                    end
`ifdef DAC_SCHED_TIMEOUT_EN
                    if (tmr_q == TO_LAST) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = GAP;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
`endif
                end
            end
            GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Run enable low behaves like reset except that the arbiter pointer survives.
        if (!key_state) begin
            state_d = IDLE;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
            cnt_d   = '0;
            data_d  = '0;
            ack_d   = '0;
            err_d   = 1'b0;
            seen_d  = 1'b0;
            tmr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            grant_q <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            grant_q <= grant_d;
            tmr_q   <= tmr_d;
        end
    end

    assign ack      = ack_q;
    assign data_sdi = data_q;
    assign cs       = cs_q;
    assign sck      = sck_q;
    assign cnt_sck  = cnt_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_dac_frame_sched.sv
// Scoreboard bench for dac_frame_sched: expected acks queued at stimulus, checked by a monitor.
module tb_dac_frame_sched;

    localparam int NUM_REQ = 4;
    localparam int GAP_CYC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_state = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_data = {16'hD00D, 16'h1234, 16'hBEEF, 16'hA5C3};
    logic [3:0]  ack;
    logic [15:0] data_sdi;
    logic        cs, sck, ldac, busy, err;
    logic [4:0]  cnt_sck;
    logic        ldac_en = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  ack;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic        mon_prev_cs = 1'b1;
    logic [15:0] frame_data = '0;
    logic        frame_stable = 1'b1;

    dac_frame_sched #(.NUM_REQ(NUM_REQ), .SCK_HALF(4), .GAP_CYC(GAP_CYC), .LDAC_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .key_state(key_state), .req(req), .req_data(req_data),
        .ack(ack), .data_sdi(data_sdi), .cs(cs), .sck(sck), .cnt_sck(cnt_sck),
        .ldac(ldac), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serializer stand-in: a 3-cycle ldac low pulse shortly after each cs rise.
    initial begin
        ldac = 1'b1;
        forever begin
            @(posedge cs);
            if (ldac_en) begin
                repeat (2) @(posedge clk);
                #1 ldac = 1'b0;
                repeat (3) @(posedge clk);
                #1 ldac = 1'b1;
            end
        end
    end

    // Monitor: track frame data while cs is low, pop and compare on every ack pulse.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev_cs = 1'b1;
        end else begin
            if (!cs) begin
                if (mon_prev_cs) begin
                    frame_data   = data_sdi;
                    frame_stable = 1'b1;
                end else if (data_sdi !== frame_data) begin
                    frame_stable = 1'b0;
                end
            end
            mon_prev_cs = cs;
            if (ack !== 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_order", 32'(ack), 32'(mon_e.ack));
                    chk("frame_data", 32'(frame_data), 32'(mon_e.data));
                    chk("data_stable", 32'(frame_stable), 32'd1);
                end
            end
        end
    end

    task automatic run_frames(input int n, input int budget);
        int   acks = 0;
        int   hi_len = 0;
        logic prev_cs = 1'b1;
        bit   started = 0;
        for (int i = 0; i < budget && acks < n; i++) begin
            if (ack != 4'b0) begin
                acks++;
                chk("cnt_clear_at_ack", 32'(cnt_sck), 32'd0);
                if (acks == n) req = '0;
            end
            if (cs) begin
                hi_len++;
            end else begin
                if (prev_cs && started) chk("gap_ge_8", 32'(hi_len >= GAP_CYC), 32'd1);
                started = 1;
                hi_len  = 0;
            end
            prev_cs = cs;
            tick(1);
        end
        chk("frames_done", acks, n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick(1);
        chk("back_to_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_cnt(input logic [4:0] v, input int budget);
        int i;
        for (i = 0; i < budget && cnt_sck != v; i++) tick(1);
        chk("reach_cnt_sck", 32'(cnt_sck), 32'(v));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cs"},   32'(cs), 32'd1);
        chk({tag, "_sck"},  32'(sck), 32'd0);
        chk({tag, "_cnt"},  32'(cnt_sck), 32'd0);
        chk({tag, "_ack"},  32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
    endtask

    initial begin
        int len;
        int bad;
        tick(2);
        check_idle_outputs("reset");
        chk("reset_data", 32'(data_sdi), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single request: 128-cycle cs low window, cnt_sck/sck stepping, data held.
        exp_q.push_back('{4'b0001, 16'hA5C3});
        req = 4'b0001;
        for (int i = 0; i < 20 && cs; i++) tick(1);
        chk("cs_fell", 32'(cs), 32'd0);
        chk("first_data", 32'(data_sdi), 32'hA5C3);
        len = 0;
        bad = 0;
        while (!cs && len < 300) begin
            if (cnt_sck != 5'(len / 8) || sck != ((len % 8) >= 4) || data_sdi != 16'hA5C3) bad++;
            len++;
            tick(1);
        end
        chk("cs_low_len", len, 128);
        chk("cnt_sck_sck_steps", bad, 0);
        chk("latch_cnt_16", 32'(cnt_sck), 32'd16);
        chk("latch_sck_low", 32'(sck), 32'd0);
        run_frames(1, 400);
        wait_idle(100);

        // Round robin from pointer 0 with all requests held.
        do_reset;
        exp_q.push_back('{4'b0001, 16'hA5C3});
        exp_q.push_back('{4'b0010, 16'hBEEF});
        exp_q.push_back('{4'b0100, 16'h1234});
        exp_q.push_back('{4'b1000, 16'hD00D});
        exp_q.push_back('{4'b0001, 16'hA5C3});
        req = 4'b1111;
        run_frames(5, 2000);
        wait_idle(100);

        // Pointer wrap: serve 2 (pointer -> 3), then 4'b0101 grants 0 before 2.
        do_reset;
        exp_q.push_back('{4'b0100, 16'h1234});
        req = 4'b0100;
        run_frames(1, 400);
        wait_idle(100);
        exp_q.push_back('{4'b0001, 16'hA5C3});
        exp_q.push_back('{4'b0100, 16'h1234});
        req = 4'b0101;
        run_frames(2, 800);
        wait_idle(100);

        // Abort by key_state at cnt_sck=7, then the same requester is re-served.
        do_reset;
        exp_q.push_back('{4'b0001, 16'hA5C3});
        req = 4'b0001;
        wait_cnt(5'd7, 400);
        key_state = 1'b0;
        tick(1);
        check_idle_outputs("abort");
        tick(3);
        key_state = 1'b1;
        run_frames(1, 400);
        wait_idle(100);

        // Reset in LATCH after serving requester 1; pointer must return to 0.
        do_reset;
        req = 4'b0010;
        wait_cnt(5'd16, 400);
        rst = 1'b1;
        req = 4'b1111;
        tick(1);
        rst = 1'b0;
        check_idle_outputs("rst_latch");
        chk("rst_latch_data", 32'(data_sdi), 32'd0);
        exp_q.push_back('{4'b0001, 16'hA5C3});
        run_frames(1, 400);
        wait_idle(100);

`ifdef DAC_SCHED_TIMEOUT_EN
        // ldac never pulses: err 64 cycles after LATCH entry, no ack.
        do_reset;
        ldac_en = 1'b0;
        req = 4'b0001;
        wait_cnt(5'd16, 400);
        len = 0;
        bad = 0;
        while (!err && len < 200) begin
            if (ack != 4'b0) bad++;
            len++;
            tick(1);
        end
        chk("timeout_err_delay", len, 64);
        chk("timeout_no_ack", bad, 0);
        req = 4'b0000;
        tick(1);
        chk("timeout_err_pulse", 32'(err), 32'd0);
        wait_idle(100);
        ldac_en = 1'b1;
`endif

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
